// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / aligned load / link result and drives the regfile write port.
// Optional retired-instruction counter output o_instret when WB_INSTRET_EN is defined.
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_wb_en,
  input  logic [1:0]      i_wb_sel,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_rf_wr,
  output logic [4:0]      o_rf_rd,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_retire,
  output logic            o_busy
`ifdef WB_INSTRET_EN
  , output logic [63:0]   o_instret
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  state_t     state, state_nx;
  logic       wb_en_q;
  logic [1:0] wb_sel_q;
  logic [2:0] funct3_q;
  logic [1:0] addr_lo_q;
  logic       xfer;

  assign o_ready  = (state != WAIT_LOAD);
  assign o_busy   = (state == WAIT_LOAD);
  assign o_retire = (state == WRITE);
  assign o_rf_wr  = o_retire && wb_en_q && (o_rf_rd != 5'd0) && (wb_sel_q != SEL_NONE);
  assign xfer     = i_valid && o_ready;

  function automatic logic [XLEN-1:0] load_align(input logic [2:0] f3, input logic [1:0] lo,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = w[16*lo[1] +: 16];
    case (f3)
      3'b000:  load_align = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_align = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_align = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_align = {{(XLEN-16){1'b0}}, h};
      default: load_align = w;  // LW and reserved encodings
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (xfer) state_nx = (i_wb_sel == SEL_LOAD) ? WAIT_LOAD : WRITE;
      WAIT_LOAD: if (i_dmem_ack) state_nx = WRITE;
      WRITE:     state_nx = !xfer ? IDLE : (i_wb_sel == SEL_LOAD) ? WAIT_LOAD : WRITE;
      default:   state_nx = IDLE;
    endcase
  end

  // Non-load results are latched at transfer; load data overwrites on ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en_q    <= 1'b0;
      wb_sel_q   <= SEL_ALU;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      o_rf_rd    <= 5'd0;
      o_rf_wdata <= '0;
    end else if (xfer) begin
      wb_en_q    <= i_wb_en;
      wb_sel_q   <= i_wb_sel;
      funct3_q   <= i_funct3;
      addr_lo_q  <= i_addr_lo;
      o_rf_rd    <= i_rd;
      o_rf_wdata <= (i_wb_sel == SEL_LINK) ? i_pc + XLEN'(PC_INC) : i_alu_result;
    end else if (state == WAIT_LOAD && i_dmem_ack) begin
      o_rf_wdata <= load_align(funct3_q, addr_lo_q, i_dmem_rdata);
    end
  end

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        o_instret <= 64'd0;
    else if (o_retire) o_instret <= o_instret + 64'd1;
  end
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the DHRUT-V pipeline, between the memory stage and the register file write port.
- Accepts one retiring instruction per handshake and selects its result: ALU result, aligned/extended load data, or PC+4.
- Waits for data-memory load completion when needed.
- Drives the register file write port (write enable, rd, data) for exactly one cycle per retired instruction.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- PC_INC, 4, increment added to i_pc for link writes (JAL/JALR).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- i_valid  input  1  memory stage presents an instruction
- o_ready  output  1  stage can accept an instruction this cycle
- i_wb_en  input  1  instruction writes rd
- i_wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+PC_INC, 11 none
- i_rd  input  5  destination register
- i_alu_result  input  XLEN  ALU result
- i_pc  input  XLEN  instruction PC
- i_funct3  input  3  load type
- i_addr_lo  input  2  load byte offset (address bits 1:0)
- i_dmem_ack  input  1  load data valid
- i_dmem_rdata  input  XLEN  raw 32-bit load word
- o_rf_wr  output  1  register file write enable
- o_rf_rd  output  5  register file write address
- o_rf_wdata  output  XLEN  register file write data
- o_retire  output  1  one-cycle pulse per retired instruction
- o_busy  output  1  high in WAIT_LOAD

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE.
  - All outputs 0, except o_ready=1 from the first cycle after reset.
  - All captured fields cleared.
  - Reset asserted in any state, including WAIT_LOAD, abandons the instruction in flight with no write and no retire.
- Handshake:
  - Transfer occurs on a posedge with i_valid && o_ready.
  - o_ready = (state != WAIT_LOAD); it is purely combinational on state.
- FSM states IDLE, WAIT_LOAD, WRITE:
  - IDLE: on transfer, capture rd, wb_en, wb_sel, funct3, addr_lo, alu_result, pc. Go to WAIT_LOAD if wb_sel=01, else go to WRITE with the result latched.
  - WAIT_LOAD: on i_dmem_ack, latch aligned/extended load data and go to WRITE; otherwise stay. Wait time is unbounded.
  - WRITE: o_retire=1 and o_rf_wr = wb_en && (rd!=0) && (wb_sel!=11). On transfer in the same cycle, capture the new instruction and go to WAIT_LOAD or WRITE; otherwise go to IDLE.
- Throughput and latency:
  - Non-load instructions: 1 per cycle; write occurs in the cycle after transfer.
  - Loads: write occurs in the cycle after ack. Ack is sampled only in WAIT_LOAD, so ack can arrive no earlier than 1 cycle after transfer.
- i_dmem_ack is ignored in IDLE and WRITE.
- o_rf_rd and o_rf_wdata are registered. They hold their last value outside WRITE but are only meaningful while o_rf_wr=1.
- Results:
  - 00: alu_result.
  - 10: pc+PC_INC, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - 11: no write; o_retire still pulses.
- Load alignment, byte b = rdata[8*addr_lo +: 8], half h = rdata[16*addr_lo[1] +: 16]:
  - LB (000): sign-extend b.
  - LH (001): sign-extend h.
  - LW (010): full word.
  - LBU (100): zero-extend b.
  - LHU (101): zero-extend h.
  - Reserved 011/110/111: treated as LW.
  - addr_lo[0] is ignored for halfwords; misalignment is trapped upstream.
- rd=0 never asserts o_rf_wr but still retires.
- o_busy = (state == WAIT_LOAD).

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined:
  - Adds output o_instret, 64 bits: retired-instruction counter.
  - Reset to 0; increments by 1 on every cycle with o_retire=1; wraps from 2^64-1 to 0.
  - Value is registered, so it reflects retirements up to the previous cycle.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release -> o_rf_wr=0, o_retire=0, o_busy=0, o_ready=1 in the first cycle after release.
- Back-to-back ALU ops:
  - Stimulus: i_valid=1 on 3 consecutive cycles, rd=5/6/7, alu_result=0x11/0x22/0x33.
  - Required: o_rf_wr=1 on 3 consecutive cycles starting 1 cycle after the first transfer, writing x5=0x11, x6=0x22, x7=0x33; o_ready stays 1.
- Load wait:
  - Stimulus: LB, addr_lo=3, rd=9; ack after 4 cycles with rdata=0x80FF_0000.
  - Required: o_ready=0 and o_busy=1 for 4 cycles; next cycle write x9=0xFFFFFF80.
- Load variants with rdata=0x80FF_0000:
  - LHU, addr_lo=2 -> 0x000080FF.
  - LH, addr_lo=2 -> 0xFFFF80FF.
  - LBU, addr_lo=2 -> 0x000000FF.
- rd=0 and wb_sel cases:
  - rd=0 with wb_en=1 -> o_retire=1, o_rf_wr=0.
  - wb_sel=10, pc=0x100, rd=1 -> write x1=0x104.
- Reset mid-load: reset asserted in WAIT_LOAD, then ack asserted -> no write, no retire, state IDLE. With WB_INSTRET_EN defined, o_instret=0.
